sram_axi_rd_arbiter: RTL
========================

Name: sram_axi_rd_arbiter

Overview:
- Shares one AXI read address/data channel pair between two SRAM-style read requesters: instruction fetch (AXI id 0) and data load (AXI id 1).
- Selects one request, holds it stable on AR until handshake, counts outstanding reads per id, and routes R beats back by rid.
- Sits between the CPU-side SRAM interfaces and the AXI master port, upstream of the write-channel logic.

Parameters:
- MAX_OUTSTANDING, 2, maximum reads in flight per id (1..3).
- CNT_W, 2, width of each outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_rd_req  in  1  instruction read request, held until addr_ok
- inst_rd_addr  in  32  instruction read address
- inst_rd_size  in  2  instruction read size (log2 bytes)
- inst_rd_addr_ok  out  1  instruction request accepted (one-cycle pulse)
- inst_rd_data_ok  out  1  instruction read data valid (one-cycle pulse)
- inst_rd_rdata  out  32  instruction read data
- data_rd_req, data_rd_addr, data_rd_size, data_rd_addr_ok, data_rd_data_ok, data_rd_rdata: same directions and widths, for the data port
- arid  out  4; araddr  out  32; arsize  out  3; arvalid  out  1; arready  in  1: AXI AR channel (arlen=0, arburst=1, arlock=0, arcache=0, arprot=0 tied)
- rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1: AXI R channel
- rd_err  out  1  sticky: error response, unknown rid, or unmatched response

Behaviour:
- Reset values: arvalid=0, arid/araddr/arsize=0, all addr_ok/data_ok=0, rdatas=0, rd_err=0, both counters=0. rready=0 during reset, then 1.
- FSM IDLE/SEND:
  - IDLE: grant when a requester has req=1 and its counter < MAX_OUTSTANDING. Fixed priority: data over inst. Grant latches id, addr, and {1'b0,size} into AR registers and sets arvalid next cycle. Go to SEND.
  - SEND: arvalid=1 and AR payload held stable until arready. On arvalid&&arready: pulse the granted port's addr_ok in the same cycle (combinational from handshake), drop arvalid next cycle, return to IDLE.
  - Minimum spacing between AR handshakes: 2 cycles.
- Requesters must hold req and payload until addr_ok. Requests are not sampled again while in SEND.
- Counters:
  - +1 on AR handshake for that id; -1 on R handshake (rvalid&&rready&&rlast) for that id.
  - Both in the same cycle for the same id: counter unchanged.
  - Saturates; never wraps.
- R routing:
  - rid==0 drives inst_rd_data_ok and inst_rd_rdata; rid==1 drives the data pair.
  - Registered: data_ok rises 1 cycle after the R handshake and lasts exactly 1 cycle. rdata is held until the next response for that port.
- Boundaries:
  - Counter at MAX: that requester is not granted; the other may be.
  - rid not 0/1, rresp!=0, or R beat for an id with counter=0: beat is consumed, no data_ok, counter unchanged, rd_err set.
  - Responses for different ids may interleave in any order.
  - Reset mid-transaction: arvalid drops next cycle, counters cleared, in-flight responses arriving after reset are treated as unmatched (rd_err).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both ports are eligible in IDLE, grant goes to the port not granted most recently; a 1-bit last-grant register resets to inst, so data wins the first tie.
- Undefined: fixed data-over-inst priority as above.

Decomposition:
- Shared package sram_axi_pkg:
  - ID_INST=4'd0, ID_DATA=4'd1.
  - Tied AXI constants (ARLEN_SINGLE, ARBURST_INCR, zero lock/cache/prot).
  - FSM state enum {ST_IDLE, ST_SEND}.
- One natural sub-module, rd_outstanding_cnt: saturating up/down counter with full/empty flags, instantiated twice (one per id).

Test Plan:
- Single inst read 0x1FC00000 size 2, arready immediate: AR carries id 0, addr 0x1FC00000, arsize 3'b010; inst_rd_addr_ok pulses on handshake. R returns 0xDEADBEEF rid 0; inst_rd_data_ok pulses 1 cycle later with rdata 0xDEADBEEF.
- Simultaneous inst and data requests, fixed priority: data (id 1) is issued first, inst second. With ARB_ROUND_ROBIN_EN, a second simultaneous pair issues inst first.
- arready held low 5 cycles: arvalid stays 1 and araddr/arid stay constant all 5 cycles; no addr_ok until arready=1.
- Three back-to-back data reads with no R, MAX_OUTSTANDING=2: the third is stalled (no arvalid). One R for rid 1 returns, then the third issues.
- Out-of-order responses: data then inst outstanding, R rid 0 arrives before rid 1; each data_ok goes to the correct port with the correct data.
- R with rid 5, then R with rresp=2'b10: no data_ok on either port, rd_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/sram_axi_pkg.sv
// Shared AXI read-arbiter types and constants: fixed ids, tied AR fields, FSM states.
package sram_axi_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SIZE_W = 3;

   localparam logic [ID_W-1:0] ID_INST = 4'd0;
   localparam logic [ID_W-1:0] ID_DATA = 4'd1;

   localparam logic [7:0] ARLEN_SINGLE = 8'd0;
   localparam logic [1:0] ARBURST_INCR = 2'd1;
   localparam logic [1:0] ARLOCK_NONE  = 2'd0;
   localparam logic [3:0] ARCACHE_NONE = 4'd0;
   localparam logic [2:0] ARPROT_NONE  = 3'd0;

   typedef enum logic {ST_IDLE, ST_SEND} arb_state_e;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
   } ar_req_t;

endpackage

// File: rtl/sram_axi_rd_arbiter_cnt.sv
// Saturating up/down count of reads in flight for one AXI id.
module rd_outstanding_cnt #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full_c,
   output logic empty_c
);

   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] cnt;

   assign full_c  = (cnt >= MAX_VAL);
   assign empty_c = (cnt == '0);

   // Simultaneous inc and dec cancel; both ends saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec && !full_c) begin
         cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc && !empty_c) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sram_axi_rd_arbiter.sv
// Arbitrates instruction/data SRAM-style reads onto one AXI AR/R pair and routes responses by rid.
// Optional ARB_ROUND_ROBIN_EN: ties alternate between ports instead of data-over-inst priority.
module sram_axi_rd_arbiter
   import sram_axi_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 2
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_rd_req,
   input  logic [ADDR_W-1:0] inst_rd_addr,
   input  logic [1:0]        inst_rd_size,
   output logic              inst_rd_addr_ok,
   output logic              inst_rd_data_ok,
   output logic [DATA_W-1:0] inst_rd_rdata,

   input  logic              data_rd_req,
   input  logic [ADDR_W-1:0] data_rd_addr,
   input  logic [1:0]        data_rd_size,
   output logic              data_rd_addr_ok,
   output logic              data_rd_data_ok,
   output logic [DATA_W-1:0] data_rd_rdata,

   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [SIZE_W-1:0] arsize,
   output logic              arvalid,
   input  logic              arready,

   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,

   output logic              rd_err
);

   arb_state_e state;
   ar_req_t    ar_q;
   ar_req_t    grant_c;
   logic       gnt_data_q;

   logic inst_full_c, inst_empty_c, data_full_c, data_empty_c;
   logic inst_elig_c, data_elig_c, pick_data_c, ar_hs_c;
   logic r_beat_c, inst_match_c, data_match_c, inst_ret_c, data_ret_c, r_err_c;

   assign arid   = ar_q.id;
   assign araddr = ar_q.addr;
   assign arsize = ar_q.size;

   // addr_ok is the AR handshake itself, steered to whichever port owns the slot.
   assign ar_hs_c         = arvalid && arready;
   assign inst_rd_addr_ok = ar_hs_c && !gnt_data_q;
   assign data_rd_addr_ok = ar_hs_c &&  gnt_data_q;

   assign inst_elig_c = inst_rd_req && !inst_full_c;
   assign data_elig_c = data_rd_req && !data_full_c;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_data_q;
   // On a tie, hand the slot to whoever lost the previous tie.
   assign pick_data_c = data_elig_c && !(inst_elig_c && last_data_q);
`else
   assign pick_data_c = data_elig_c;
`endif

   always_comb begin
      grant_c = '0;
      if (pick_data_c) begin
         grant_c.id   = ID_DATA;
         grant_c.addr = data_rd_addr;
         grant_c.size = {1'b0, data_rd_size};
      end else begin
         grant_c.id   = ID_INST;
         grant_c.addr = inst_rd_addr;
         grant_c.size = {1'b0, inst_rd_size};
      end
   end

   // Responses only count when they match an outstanding read with OKAY status.
   assign r_beat_c     = rvalid && rready;
   assign inst_match_c = (rresp == 2'b00) && (rid == ID_INST) && !inst_empty_c;
   assign data_match_c = (rresp == 2'b00) && (rid == ID_DATA) && !data_empty_c;
   assign inst_ret_c   = r_beat_c && rlast && inst_match_c;
   assign data_ret_c   = r_beat_c && rlast && data_match_c;
   assign r_err_c      = r_beat_c && !inst_match_c && !data_match_c;

   rd_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_inst_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inst_rd_addr_ok),
      .dec     (inst_ret_c),
      .full_c  (inst_full_c),
      .empty_c (inst_empty_c)
   );

   rd_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_data_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (data_rd_addr_ok),
      .dec     (data_ret_c),
      .full_c  (data_full_c),
      .empty_c (data_empty_c)
   );

   // AR issue FSM: payload is frozen from grant until handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ar_q       <= '0;
         arvalid    <= 1'b0;
         gnt_data_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (inst_elig_c || data_elig_c) begin
                  ar_q       <= grant_c;
                  arvalid    <= 1'b1;
                  gnt_data_q <= pick_data_c;
                  state      <= ST_SEND;
`ifdef ARB_ROUND_ROBIN_EN
                  if (inst_elig_c && data_elig_c) begin
                     last_data_q <= pick_data_c;
                  end
`endif
               end
            end
            ST_SEND: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // R side: one-cycle data_ok pulse, rdata held per port, sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         rready          <= 1'b0;
         inst_rd_data_ok <= 1'b0;
         data_rd_data_ok <= 1'b0;
         inst_rd_rdata   <= '0;
         data_rd_rdata   <= '0;
         rd_err          <= 1'b0;
      end else begin
         rready          <= 1'b1;
         inst_rd_data_ok <= inst_ret_c;
         data_rd_data_ok <= data_ret_c;
         if (inst_ret_c) begin
            inst_rd_rdata <= rdata;
         end
         if (data_ret_c) begin
            data_rd_rdata <= rdata;
         end
         if (r_err_c) begin
            rd_err <= 1'b1;
         end
      end
   end

endmodule
